// File: rtl/pu_stream_buf.sv
// pu_stream_buf: ping-pong capture/serializer between two layer processing units.
// Captures a whole VEC_LEN x DATA_WIDTH result vector on done_i and streams it
// one signed element per cycle, index 0 first, over a valid/ready handshake.
// Two banks let the upstream PU produce the next vector while one is draining.
// Optional feature macro: PU_STREAM_BUF_DROP_CNT_EN (adds drop_cnt_o).
module pu_stream_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LEN    = 128,
    localparam int PTR_W     = $clog2(VEC_LEN)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic                          done_i,
    input  logic [DATA_WIDTH*VEC_LEN-1:0] vec_i,
    input  logic                          ready_i,
    output logic                          valid_o,
    output logic [DATA_WIDTH-1:0]         dout_o,
    output logic                          last_o,
    output logic                          first_o,
    output logic                          full_o,
    output logic                          overflow_o
`ifdef PU_STREAM_BUF_DROP_CNT_EN
    ,
    output logic [7:0]                    drop_cnt_o
`endif
);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(VEC_LEN - 1);
    localparam logic [PTR_W-1:0] ZERO_IDX = {PTR_W{1'b0}};

    // Vector storage (deliberately not reset) and control state
    logic [DATA_WIDTH*VEC_LEN-1:0] bank0;
    logic [DATA_WIDTH*VEC_LEN-1:0] bank1;
    logic [1:0]                    full;
    logic                          wr_bank;
    logic                          rd_bank;
    logic [PTR_W-1:0]              rd_ptr;
    logic                          overflow;

    // Next-state and event decode
    logic                          valid;
    logic                          xfer;
    logic                          at_last;
    logic                          releasing;
    logic                          cap_ok;
    logic                          drop;
    logic [1:0]                    full_nxt;
    logic [PTR_W-1:0]              rd_ptr_nxt;
    logic [DATA_WIDTH*VEC_LEN-1:0] rd_vec;
    logic [DATA_WIDTH-1:0]         elem;

    // Decode handshake events, capture/drop decision and next control state
    always_comb begin
        valid     = full[rd_bank];
        xfer      = valid & ready_i;
        at_last   = (rd_ptr == LAST_IDX);
        releasing = xfer & at_last;
        // A capture into the bank being released at this very edge is allowed:
        // the old vector's final element leaves as the new vector arrives.
        cap_ok    = done_i & (~full[wr_bank] | (releasing & (wr_bank == rd_bank)));
        drop      = done_i & ~cap_ok;
        // Capture takes precedence over release when both hit the same bank
        full_nxt[0] = (cap_ok & (wr_bank == 1'b0)) ? 1'b1 :
                      ((releasing & (rd_bank == 1'b0)) ? 1'b0 : full[0]);
        full_nxt[1] = (cap_ok & (wr_bank == 1'b1)) ? 1'b1 :
                      ((releasing & (rd_bank == 1'b1)) ? 1'b0 : full[1]);
        rd_ptr_nxt  = xfer ? (at_last ? ZERO_IDX : (rd_ptr + PTR_W'(1))) : rd_ptr;
    end

    // Control state register; clear_i flushes ahead of any capture or transfer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full     <= 2'b00;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            rd_ptr   <= ZERO_IDX;
            overflow <= 1'b0;
        end else if (clear_i) begin
            full     <= 2'b00;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            rd_ptr   <= ZERO_IDX;
            overflow <= 1'b0;
        end else begin
            full     <= full_nxt;
            wr_bank  <= wr_bank ^ cap_ok;
            rd_bank  <= rd_bank ^ releasing;
            rd_ptr   <= rd_ptr_nxt;
            overflow <= overflow | drop;
        end
    end

    // Bank capture; contents carry no reset since full[] qualifies them
    always_ff @(posedge clk_i) begin
        if (cap_ok && !clear_i) begin
            if (wr_bank == 1'b0) begin
                bank0 <= vec_i;
            end else begin
                bank1 <= vec_i;
            end
        end
    end

`ifdef PU_STREAM_BUF_DROP_CNT_EN
    logic [7:0] drop_cnt;

    // Saturating count of dropped vectors, advancing with the overflow flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt <= 8'd0;
        end else if (clear_i) begin
            drop_cnt <= 8'd0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end else begin
            drop_cnt <= drop_cnt;
        end
    end

    assign drop_cnt_o = drop_cnt;
`endif

    // Output decode from registered state only (no input-to-output path)
    always_comb begin
        rd_vec = rd_bank ? bank1 : bank0;
        elem   = rd_vec[rd_ptr * DATA_WIDTH +: DATA_WIDTH];
    end

    assign valid_o    = valid;
    assign dout_o     = valid ? elem : {DATA_WIDTH{1'b0}};
    assign last_o     = valid & at_last;
    assign first_o    = valid & (rd_ptr == ZERO_IDX);
    assign full_o     = full[0] & full[1];
    assign overflow_o = overflow;

endmodule

// File: tb/tb_pu_stream_buf.sv
// Directed self-checking bench for pu_stream_buf (DATA_WIDTH=8, VEC_LEN=128).
// Vectors are built as element k = base + stride*k (truncated to 8 bits).
module tb_pu_stream_buf;

    localparam int DW = 8;
    localparam int VL = 128;
    localparam int VW = DW * VL;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          clear_i;
    logic          done_i;
    logic [VW-1:0] vec_i;
    logic          ready_i;
    logic          valid_o;
    logic [DW-1:0] dout_o;
    logic          last_o;
    logic          first_o;
    logic          full_o;
    logic          overflow_o;
`ifdef PU_STREAM_BUF_DROP_CNT_EN
    logic [7:0]    drop_cnt_o;
`endif

    int tests = 0;
    int fails = 0;

    pu_stream_buf #(.DATA_WIDTH(DW), .VEC_LEN(VL)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (clear_i),
        .done_i     (done_i),
        .vec_i      (vec_i),
        .ready_i    (ready_i),
        .valid_o    (valid_o),
        .dout_o     (dout_o),
        .last_o     (last_o),
        .first_o    (first_o),
        .full_o     (full_o),
        .overflow_o (overflow_o)
`ifdef PU_STREAM_BUF_DROP_CNT_EN
        ,
        .drop_cnt_o (drop_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [DW-1:0] elt(input int b, input int s, input int k);
        return DW'(b + s * k);
    endfunction

    function automatic logic [VW-1:0] mkvec(input int b, input int s);
        logic [VW-1:0] v;
        for (int k = 0; k < VL; k++) v[k*DW +: DW] = elt(b, s, k);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock; sample point is 1 time unit after the rising edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic capture(input int b, input int s);
        done_i = 1'b1;
        vec_i  = mkvec(b, s);
        step();
        done_i = 1'b0;
    endtask

    // Stream nv back-to-back vectors with ready held high; optional done_i
    // injection at stream cycle inj_k (-1 for none).
    task automatic stream(input int nv, input int b0, input int s0, input int b1,
                          input int s1, input int b2, input int s2, input int inj_k,
                          input int ib, input int is, input string tag);
        int v;
        int i;
        int b;
        int s;
        ready_i = 1'b1;
        for (int k = 0; k < nv * VL; k++) begin
            v = k / VL;
            i = k % VL;
            b = (v == 0) ? b0 : ((v == 1) ? b1 : b2);
            s = (v == 0) ? s0 : ((v == 1) ? s1 : s2);
            chk({tag, "_valid"}, valid_o, 1'b1);
            chk({tag, "_dout"}, dout_o, elt(b, s, i));
            chk({tag, "_first"}, first_o, (i == 0));
            chk({tag, "_last"}, last_o, (i == VL - 1));
            if (k == inj_k) begin
                done_i = 1'b1;
                vec_i  = mkvec(ib, is);
            end else begin
                done_i = 1'b0;
            end
            step();
        end
        done_i = 1'b0;
        chk({tag, "_idle"}, valid_o, 1'b0);
    endtask

    initial begin
        int idx;
        int c;
        rst_i   = 1'b1;
        clear_i = 1'b0;
        done_i  = 1'b0;
        vec_i   = '0;
        ready_i = 1'b0;
        step();
        step();
        // reset state
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_dout", dout_o, 8'h00);
        chk("rst_last", last_o, 1'b0);
        chk("rst_first", first_o, 1'b0);
        chk("rst_full", full_o, 1'b0);
        chk("rst_ovf", overflow_o, 1'b0);
        rst_i = 1'b0;
        step();

        // 1: single vector -64..63, zero-latency valid, drains in 128 cycles
        ready_i = 1'b1;
        capture(-64, 1);
        chk("t1_dout0", dout_o, 8'hC0);
        stream(1, -64, 1, 0, 0, 0, 0, -1, 0, 0, "t1");

        // 2: two vectors 3 cycles apart, no bubble between them
        capture(8'h11, 0);
        stream(2, 8'h11, 0, 8'h22, 0, 0, 0, 2, 8'h22, 0, "t2");

        // 3: third vector while both banks full is dropped
        ready_i = 1'b0;
        capture(0, 1);
        capture(255, -1);
        chk("t3_full", full_o, 1'b1);
        chk("t3_ovf_pre", overflow_o, 1'b0);
        capture(8'h55, 0);
        chk("t3_ovf", overflow_o, 1'b1);
        chk("t3_full_post", full_o, 1'b1);
`ifdef PU_STREAM_BUF_DROP_CNT_EN
        chk("t3_dropcnt", drop_cnt_o, 8'd1);
`endif
        stream(2, 0, 1, 255, -1, 0, 0, -1, 0, 0, "t3");
        chk("t3_ovf_sticky", overflow_o, 1'b1);

        // 4: ready pattern 1,0,0,... each element exactly once, in order
        ready_i = 1'b0;
        capture(1, 3);
        idx = 0;
        c = 0;
        while (idx < VL && c < 1000) begin
            chk("t4_valid", valid_o, 1'b1);
            chk("t4_dout", dout_o, elt(1, 3, idx));
            chk("t4_last", last_o, (idx == VL - 1));
            ready_i = (c % 3 == 0);
            if (ready_i) idx++;
            step();
            c++;
        end
        ready_i = 1'b0;
        chk("t4_count", idx[15:0], 16'(VL));
        chk("t4_idle", valid_o, 1'b0);

        // 5: capture on the same edge the pending-full bank releases
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("t5_clr_ovf", overflow_o, 1'b0);
        capture(5, 1);
        capture(9, 2);
        chk("t5_full", full_o, 1'b1);
        stream(3, 5, 1, 9, 2, 100, -1, VL - 1, 100, -1, "t5");
        chk("t5_ovf", overflow_o, 1'b0);

        // 6a: async reset at element 50 discards the stream and overflow
        ready_i = 1'b0;
        capture(3, 1);
        capture(7, 1);
        capture(8'h77, 0);
        chk("t6_ovf_set", overflow_o, 1'b1);
        ready_i = 1'b1;
        for (int k = 0; k < 50; k++) step();
        chk("t6_dout50", dout_o, elt(3, 1, 50));
        #2 rst_i = 1'b1;
        #1;
        chk("t6_rst_valid", valid_o, 1'b0);
        chk("t6_rst_ovf", overflow_o, 1'b0);
        chk("t6_rst_full", full_o, 1'b0);
`ifdef PU_STREAM_BUF_DROP_CNT_EN
        chk("t6_rst_dropcnt", drop_cnt_o, 8'd0);
`endif
        step();
        rst_i = 1'b0;
        step();
        capture(40, -2);
        chk("t6_restart_first", first_o, 1'b1);
        chk("t6_restart_dout", dout_o, elt(40, -2, 0));

        // 6b: clear at element 50 beats a simultaneous done_i and transfer
        for (int k = 0; k < 50; k++) step();
        chk("t6c_dout50", dout_o, elt(40, -2, 50));
        ready_i = 1'b0;
        capture(11, 1);
        capture(8'h66, 0);
        chk("t6c_ovf_set", overflow_o, 1'b1);
        ready_i = 1'b1;
        clear_i = 1'b1;
        done_i  = 1'b1;
        vec_i   = mkvec(8'h99, 0);
        chk("t6c_valid_pre", valid_o, 1'b1);
        step();
        clear_i = 1'b0;
        done_i  = 1'b0;
        chk("t6c_valid", valid_o, 1'b0);
        chk("t6c_ovf", overflow_o, 1'b0);
        chk("t6c_full", full_o, 1'b0);
`ifdef PU_STREAM_BUF_DROP_CNT_EN
        chk("t6c_dropcnt", drop_cnt_o, 8'd0);
`endif
        capture(-100, 1);
        stream(1, -100, 1, 0, 0, 0, 0, -1, 0, 0, "t6r");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
